// File: rtl/time_of_day_counter.sv
// Real-time clock core: divides the board clock to a 1 Hz tick and keeps
// hours/minutes/seconds. It supports a range-checked runtime time set,
// run/hold control, a 12 h view and per-unit tick strobes.
module time_of_day_counter #(
  parameter int unsigned CLK_HZ  = 50_000_000,
  parameter int unsigned PRESC_W = $clog2(CLK_HZ)
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       run,
  input  logic       set_valid,
  input  logic [4:0] set_hours,
  input  logic [5:0] set_minutes,
  input  logic [5:0] set_seconds,
  output logic       set_error,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [4:0] hours,
  output logic [3:0] hours_12,
  output logic       pm,
  output logic       sec_tick,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_tick
);

  localparam logic [PRESC_W-1:0] PrescMax = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [5:0]         seconds_q, seconds_d;
  logic [5:0]         minutes_q, minutes_d;
  logic [4:0]         hours_q, hours_d;
  logic               sec_tick_q, sec_tick_d;
  logic               min_tick_q, min_tick_d;
  logic               hour_tick_q, hour_tick_d;
  logic               day_tick_q, day_tick_d;
  logic               set_error_q, set_error_d;

  logic set_ok;
  logic presc_wrap;
  logic sec_wrap, min_wrap, hour_wrap;

  // Next-state: an accepted set has priority over counting; the whole cascade
  // is resolved from current register values so every field moves on one edge.
  always_comb begin
    set_ok     = set_valid && (set_hours < 5'd24) && (set_minutes < 6'd60)
                 && (set_seconds < 6'd60);
    presc_wrap = run && (presc_q == PrescMax);
    sec_wrap   = (seconds_q == 6'd59);
    min_wrap   = (minutes_q == 6'd59);
    hour_wrap  = (hours_q == 5'd23);

    presc_d     = presc_q;
    seconds_d   = seconds_q;
    minutes_d   = minutes_q;
    hours_d     = hours_q;
    sec_tick_d  = 1'b0;
    min_tick_d  = 1'b0;
    hour_tick_d = 1'b0;
    day_tick_d  = 1'b0;
    set_error_d = 1'b0;

    if (set_ok) begin
      presc_d   = '0;
      seconds_d = set_seconds;
      minutes_d = set_minutes;
      hours_d   = set_hours;
    end else begin
      // A rejected set does not disturb normal counting.
      set_error_d = set_valid;
      if (run) begin
        if (presc_wrap) begin
          presc_d    = '0;
          sec_tick_d = 1'b1;
          if (sec_wrap) begin
            seconds_d  = '0;
            min_tick_d = 1'b1;
            if (min_wrap) begin
              minutes_d   = '0;
              hour_tick_d = 1'b1;
              if (hour_wrap) begin
                hours_d    = '0;
                day_tick_d = 1'b1;
              end else begin
                hours_d = hours_q + 5'd1;
              end
            end else begin
              minutes_d = minutes_q + 6'd1;
            end
          end else begin
            seconds_d = seconds_q + 6'd1;
          end
        end else begin
          presc_d = presc_q + PRESC_W'(1);
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_50MHz) begin
    if (!reset) begin
      presc_q     <= '0;
      seconds_q   <= '0;
      minutes_q   <= '0;
      hours_q     <= '0;
      sec_tick_q  <= 1'b0;
      min_tick_q  <= 1'b0;
      hour_tick_q <= 1'b0;
      day_tick_q  <= 1'b0;
      set_error_q <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      seconds_q   <= seconds_d;
      minutes_q   <= minutes_d;
      hours_q     <= hours_d;
      sec_tick_q  <= sec_tick_d;
      min_tick_q  <= min_tick_d;
      hour_tick_q <= hour_tick_d;
      day_tick_q  <= day_tick_d;
      set_error_q <= set_error_d;
    end
  end

  // 12 h view derived from the registered 24 h hours.
  always_comb begin
    if (hours_q == 5'd0) begin
      hours_12 = 4'd12;
    end else if (hours_q > 5'd12) begin
      hours_12 = 4'(hours_q - 5'd12);
    end else begin
      hours_12 = hours_q[3:0];
    end
    pm = (hours_q >= 5'd12);
  end

  assign seconds   = seconds_q;
  assign minutes   = minutes_q;
  assign hours     = hours_q;
  assign sec_tick  = sec_tick_q;
  assign min_tick  = min_tick_q;
  assign hour_tick = hour_tick_q;
  assign day_tick  = day_tick_q;
  assign set_error = set_error_q;

endmodule
